xoodyak_msg_feeder: RTL and testbench

- Upstream stage of the XOODYAK hash core.
- Accepts a message as a byte stream over a valid/ready handshake and buffers it in a local byte RAM.
- Replays the buffer to the core as a contiguous load burst with stable msg_len, then issues a single start pulse.
- Tracks the core's hash output (HASH_BYTES valid beats) to know when the core is free for the next message.

---
 rtl/xoodyak_pkg.sv | 17 +
 rtl/xoodyak_byte_ram.sv | 27 ++
 rtl/xoodyak_msg_feeder.sv | 195 +++++++++++++++++++
 tb/tb_xoodyak_msg_feeder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xoodyak_pkg.sv
// Shared types and constants for the XOODYAK hash front end.
package xoodyak_pkg;

  localparam int HASH_BYTES      = 32;
  localparam int XOODYAK_LEN_W   = 12;
  localparam int XOODYAK_MAX_LEN = 1024;

  typedef enum logic [2:0] {
    S_COLLECT   = 3'd0,
    S_PREFETCH  = 3'd1,
    S_REPLAY    = 3'd2,
    S_GAP       = 3'd3,
    S_START     = 3'd4,
    S_WAIT_HASH = 3'd5
  } feeder_state_e;

endpackage

// File: rtl/xoodyak_byte_ram.sv
// Single-port byte RAM with registered read; write and replay phases never
// overlap, so one address port serves both.
module xoodyak_byte_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Read-first: a write cycle returns the old contents, which nobody uses.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/xoodyak_msg_feeder.sv
// Buffers a host byte stream, replays it to the XOODYAK core, pulses start and
// waits for the hash. Optional watchdog: define XOODYAK_FEEDER_TIMEOUT_EN.
module xoodyak_msg_feeder #(
  parameter int MAX_LEN    = xoodyak_pkg::XOODYAK_MAX_LEN,
  parameter int LEN_W      = xoodyak_pkg::XOODYAK_LEN_W,
  parameter int START_GAP  = 5,
  parameter int HASH_BYTES = xoodyak_pkg::HASH_BYTES,
  parameter int TIMEOUT    = 4096
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             load,
  output logic [7:0]       msg,
  output logic [LEN_W-1:0] msg_len,
  output logic             start,
  input  logic             hash_valid,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             timeout
);

  import xoodyak_pkg::*;

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if ((1 << LEN_W) <= MAX_LEN) begin : g_bad_len_w
    $error("LEN_W too narrow for MAX_LEN");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  feeder_state_e    state_q, state_d;
  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [7:0]       ram_rdata;

`ifdef XOODYAK_FEEDER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            tmo_q, tmo_d;
`endif

  xoodyak_byte_ram #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (s_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = rd_cnt_q[AW-1:0];
`ifdef XOODYAK_FEEDER_TIMEOUT_EN
    wdog_d   = '0;
    tmo_d    = tmo_q;
`endif

    unique case (state_q)
      S_COLLECT: begin
        ram_addr = wr_cnt_q[AW-1:0];
        if (s_valid) begin
          ram_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + LEN_W'(1);
          // A full buffer closes the message as if s_last had arrived.
          if (s_last || (wr_cnt_q == LEN_W'(MAX_LEN - 1))) begin
            len_d   = wr_cnt_q + LEN_W'(1);
            ovf_d   = !s_last;
            state_d = S_PREFETCH;
          end
        end
      end

      S_PREFETCH: begin
        ram_addr = '0;
        rd_cnt_d = LEN_W'(1);
        state_d  = S_REPLAY;
      end

      // rd_cnt runs one address ahead of the byte currently on msg.
      S_REPLAY: begin
        rd_cnt_d = rd_cnt_q + LEN_W'(1);
        if (rd_cnt_q == len_q) begin
          cnt_d   = '0;
          state_d = (START_GAP == 0) ? S_START : S_GAP;
        end
      end

      S_GAP: begin
        cnt_d = cnt_q + LEN_W'(1);
        if (cnt_q == LEN_W'(START_GAP - 1)) begin
          state_d = S_START;
        end
      end

      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_HASH;
      end

      S_WAIT_HASH: begin
`ifdef XOODYAK_FEEDER_TIMEOUT_EN
        wdog_d = hash_valid ? '0 : (wdog_q + WD_W'(1));
`endif
        if (hash_valid) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == LEN_W'(HASH_BYTES - 1)) begin
            state_d  = S_COLLECT;
            done_d   = 1'b1;
            wr_cnt_d = '0;
            ovf_d    = 1'b0;
          end
        end
`ifdef XOODYAK_FEEDER_TIMEOUT_EN
        else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          tmo_d    = 1'b1;
          state_d  = S_COLLECT;
          wr_cnt_d = '0;
          ovf_d    = 1'b0;
        end
`endif
      end

      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_COLLECT;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

`ifdef XOODYAK_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  end
  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  assign s_ready  = (state_q == S_COLLECT);
  assign load     = (state_q == S_REPLAY);
  assign msg      = load ? ram_rdata : 8'h00;
  assign msg_len  = len_q;
  assign start    = (state_q == S_START);
  assign busy     = (state_q != S_COLLECT);
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_xoodyak_msg_feeder.sv
// Scoreboard bench for xoodyak_msg_feeder: the driver pushes the expected
// replay per message, a negedge monitor pops and compares on every load beat.
module tb_xoodyak_msg_feeder;

  localparam int MAX  = 1024;
  localparam int LW   = 12;
  localparam int GAP  = 5;
  localparam int HB   = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          load;
  logic [7:0]    msg;
  logic [LW-1:0] msg_len;
  logic          start;
  logic          hash_valid = 1'b0;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          timeout;

  int total = 0;
  int bad   = 0;
  int msg_no = 0;

  logic [7:0] exp_bytes[$];
  int         exp_len_q[$];
  bit         exp_ovf_q[$];

  xoodyak_msg_feeder dut (
    .clk        (clk),
    .resetn     (resetn),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .load       (load),
    .msg        (msg),
    .msg_len    (msg_len),
    .start      (start),
    .hash_valid (hash_valid),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int beats = 0;
  int gap_cnt = 0;
  int hcnt = 0;
  int cur_len = 0;
  bit cur_ovf = 1'b0;
  bit in_burst = 1'b0;
  bit after_burst = 1'b0;
  bit wait_hash = 1'b0;

  always @(negedge clk) begin
    if (!resetn) begin
      exp_bytes.delete();
      exp_len_q.delete();
      exp_ovf_q.delete();
      in_burst = 1'b0;
      after_burst = 1'b0;
      wait_hash = 1'b0;
    end else begin
      if (wait_hash && hash_valid) hcnt++;
      if (load) begin
        if (!in_burst) begin
          if (exp_len_q.size() == 0) begin
            chk("unexpected_burst", 32'd1, 32'd0);
          end else begin
            cur_len = exp_len_q.pop_front();
            cur_ovf = exp_ovf_q.pop_front();
          end
          in_burst = 1'b1;
          after_burst = 1'b0;
          beats = 0;
        end
        beats++;
        if (exp_bytes.size() == 0) chk("unexpected_load_beat", 32'd1, 32'd0);
        else chk("msg_byte", 32'(msg), 32'(exp_bytes.pop_front()));
        chk("msg_len_during_load", 32'(msg_len), 32'(cur_len));
      end else begin
        if (in_burst) begin
          chk("burst_length", beats, cur_len);
          in_burst = 1'b0;
          after_burst = 1'b1;
          gap_cnt = 0;
        end
        if (start) begin
          chk("start_gap", gap_cnt, GAP);
          chk("overflow_at_start", 32'(overflow), 32'(cur_ovf));
          chk("msg_len_at_start", 32'(msg_len), 32'(cur_len));
          after_burst = 1'b0;
          wait_hash = 1'b1;
          hcnt = 0;
        end else if (after_burst) begin
          gap_cnt++;
          chk("gap_msg_zero", 32'(msg), 32'd0);
        end
      end
      if (done) begin
        chk("done_after_beats", hcnt, HB);
        chk("done_sready", 32'(s_ready), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_ovf_cleared", 32'(overflow), 32'd0);
        wait_hash = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  // pat: 0 -> byte i mod 256, 1 -> random data
  task automatic send_msg(input int n, input int pat, input bit with_last, input bit sparse);
    logic [7:0] b[$];
    int keep;
    int refused;
    for (int i = 0; i < n; i++) b.push_back((pat == 0) ? 8'(i) : 8'($urandom));
    keep = (n > MAX) ? MAX : n;
    for (int i = 0; i < keep; i++) exp_bytes.push_back(b[i]);
    exp_len_q.push_back(keep);
    exp_ovf_q.push_back((n > MAX) || (n == MAX && !with_last));
    refused = -1;
    for (int i = 0; i < n; i++) begin
      if (sparse) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = b[i];
      s_last  = with_last && (i == n - 1);
      if (!s_ready) begin
        refused = i;
        break;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (n > MAX) chk("sready_low_after_max", refused, MAX);
  endtask

  task automatic run_hash();
    int cyc = 0;
    int got = 0;
    while (!start && cyc < 3000) begin
      hash_valid = 1'($urandom % 2);  // must be ignored before WAIT_HASH
      @(posedge clk); #1;
      cyc++;
    end
    hash_valid = 1'b0;
    chk("start_seen", 32'(start), 32'd1);
    @(posedge clk); #1;
    chk("start_one_cycle", 32'(start), 32'd0);
    while (got < HB) begin
      hash_valid = (($urandom % 3) != 0);
      s_valid    = 1'b1;
      s_data     = 8'($urandom);
      s_last     = 1'($urandom % 2);
      chk("sready_in_wait", 32'(s_ready), 32'd0);
      if (hash_valid) got++;
      @(posedge clk); #1;
    end
    hash_valid = 1'b0;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_low_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("done_single", 32'(done), 32'd0);
    msg_no++;
    $display("message %0d: msg_len=%0d hash complete", msg_no, msg_len);
  endtask

  initial begin
    #600000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    chk("rst_sready", 32'(s_ready), 32'd1);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_msg", 32'(msg), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_msg_len", 32'(msg_len), 32'd0);

    send_msg(19, 0, 1'b1, 1'b0);   run_hash();
    send_msg(MAX, 0, 1'b1, 1'b0);  run_hash();
    send_msg(1030, 0, 1'b0, 1'b0); run_hash();
    send_msg(19, 0, 1'b1, 1'b1);   run_hash();
    for (int k = 0; k < 5; k++) begin
      send_msg(int'($urandom_range(1, 40)), 1, 1'b1, 1'($urandom % 2));
      run_hash();
    end

    // reset in the middle of a replay burst
    send_msg(19, 1, 1'b1, 1'b0);
    begin
      int seen = 0;
      int cyc = 0;
      while (seen < 5 && cyc < 50) begin
        if (load) seen++;
        @(posedge clk); #1;
        cyc++;
      end
      chk("mid_replay_reached", 32'(load), 32'd1);
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("midrst_load", 32'(load), 32'd0);
    chk("midrst_start", 32'(start), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sready", 32'(s_ready), 32'd1);
    chk("midrst_msg_len", 32'(msg_len), 32'd0);
    send_msg(3, 1, 1'b1, 1'b0);
    run_hash();

    repeat (2) @(posedge clk); #1;
    chk("scoreboard_drained", exp_bytes.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
